muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It accepts one M-extension operation per launch and drives `busy` into the hazard logic, which holds F/D/E while busy. It returns a registered 32-bit result with a one-cycle `done` pulse. Multiplies take a fixed 2-cycle stall; divides and remainders use a 32-iteration restoring divider. Divide-by-zero and signed overflow are short-circuited.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative RV32M multiply/divide unit.
// The EX stage drives the op and operands; the unit answers with busy/done/result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: two-cycle multiply, 32-iteration restoring divide,
// with divide-by-zero and signed overflow resolved in a single cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [2:0]      f3;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dsr;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [4:0]      cnt;
    logic [XLEN-1:0] result_q;

    logic            in_signed;
    logic            div_by_zero;
    logic            overflow;
    logic            launch;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] short_result;

    logic [63:0]     a64;
    logic [63:0]     b64;
    logic [63:0]     prod;
    logic [XLEN-1:0] mul_result;

    logic [XLEN:0]   rem_shift;
    logic            ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] div_result;

    assign launch      = bus.start & ~bus.kill;
    assign in_signed   = ~bus.funct3[0];
    assign div_by_zero = (bus.op_b == '0);
    assign overflow    = in_signed & (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
    assign abs_a       = (in_signed & bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    assign abs_b       = (in_signed & bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

    // Remainder of x/0 is the dividend; the quotient is all ones.
    always_comb begin
        short_result = 32'h8000_0000;
        if (div_by_zero)
            short_result = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
        else if (bus.funct3[1])
            short_result = '0;
    end

    // Low 64 bits of the 66-bit signed product are exact, so a 64-bit multiply suffices.
    assign a64        = {{32{a_reg[31] & (f3 == 3'b001 || f3 == 3'b010)}}, a_reg};
    assign b64        = {{32{b_reg[31] & (f3 == 3'b001)}}, b_reg};
    assign prod       = a64 * b64;
    assign mul_result = (f3 == 3'b000) ? prod[31:0] : prod[63:32];

    // The shifted partial remainder keeps its carry bit so large unsigned divisors work.
    assign rem_shift  = {rem, dvd[31]};
    assign ge         = (rem_shift >= {1'b0, dsr});
    assign rem_next   = ge ? (rem_shift[31:0] - dsr) : rem_shift[31:0];
    assign quo_next   = {quo[30:0], ge};
    assign neg_q      = (f3 == 3'b100) & (a_reg[31] ^ b_reg[31]);
    assign neg_r      = (f3 == 3'b110) & a_reg[31];

    always_comb begin
        div_result = quo_next;
        if (f3[1])
            div_result = neg_r ? (~rem_next + 32'd1) : rem_next;
        else if (neg_q)
            div_result = ~quo_next + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    if (!bus.funct3[2])
                        state_next = MUL;
                    else if (div_by_zero || overflow)
                        state_next = DONE;
                    else
                        state_next = DIV;
                end
            end
            MUL:  state_next = DONE;
            DIV:  if (cnt == 5'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.kill)
            state_next = IDLE;
    end

    // A flush freezes the datapath so result keeps the last completed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (!bus.kill) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        f3    <= bus.funct3;
                        a_reg <= bus.op_a;
                        b_reg <= bus.op_b;
                        dvd   <= abs_a;
                        dsr   <= abs_b;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= '0;
                        if (bus.funct3[2] && (div_by_zero || overflow))
                            result_q <= short_result;
                    end
                end
                MUL: result_q <= mul_result;
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    dvd <= {dvd[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        result_q <= div_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = ((state == IDLE) & launch) | (state == MUL) | (state == DIV);
    assign bus.done   = (state == DONE) & ~bus.kill;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply, divide, short-circuit,
// flush, reset and start-in-DONE behaviour with hand-computed expectations.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   lat;
    int   done_cnt;
    logic busy_drop;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drives a launch for one cycle; returns just after the edge that leaves cycle T.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        @(negedge clk);
        checkOutput("launch_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int exp_lat, input logic [31:0] exp_res);
        lat       = 1;
        busy_drop = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) break;
            if (!bus.busy) busy_drop = 1'b1;
            lat++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_result"}, bus.result, exp_res);
        checkOutput({tag, "_busy_low_in_done"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        #1;
        checkOutput("kill_masks_busy_idle", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
        waitDone("mul", 2, 32'hFFFF_FFEB);
        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000);
        waitDone("mulh", 2, 32'h4000_0000);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("mulhu", 2, 32'hFFFF_FFFE);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("mulhsu", 2, 32'hFFFF_FFFF);

        applyStimulus(3'b101, 32'd100, 32'd7);
        waitDone("divu", 33, 32'd14);
        applyStimulus(3'b111, 32'd100, 32'd7);
        waitDone("remu", 33, 32'd2);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_neg", 33, 32'hFFFF_FFFD);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
        waitDone("rem_neg", 33, 32'hFFFF_FFFF);

        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div_ovf", 1, 32'h8000_0000);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("rem_ovf", 1, 32'd0);
        applyStimulus(3'b100, 32'd5, 32'd0);
        waitDone("div_by_zero", 1, 32'hFFFF_FFFF);
        applyStimulus(3'b111, 32'd5, 32'd0);
        waitDone("remu_by_zero", 1, 32'd5);

        // Flush during iteration 10 (cycle T+11); result must stay at 5.
        applyStimulus(3'b101, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(negedge clk);
        checkOutput("kill_cycle_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        checkOutput("kill_busy_next", {31'd0, bus.busy}, 32'd0);
        checkOutput("kill_result_held", bus.result, 32'd5);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        checkOutput("kill_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        applyStimulus(3'b101, 32'd9, 32'd3);
        waitDone("divu_after_kill", 33, 32'd3);

        // Reset while in MUL state.
        applyStimulus(3'b000, 32'd6, 32'd6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_mid_result", bus.result, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;

        // A start raised during DONE belongs to the same instruction and is ignored.
        applyStimulus(3'b000, 32'd7, 32'd3);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd2;
        bus.op_b   = 32'd2;
        @(negedge clk);
        checkOutput("done_cycle_done", {31'd0, bus.done}, 32'd1);
        checkOutput("done_cycle_result", bus.result, 32'd21);
        checkOutput("done_cycle_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        checkOutput("start_in_done_ignored", done_cnt, 0);
        checkOutput("start_in_done_result", bus.result, 32'd21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
